// File: rtl/bert_checker_param.sv
// rtl/bert_checker_param.sv - self-synchronising PRBS7/15/23/31 bit-error-ratio checker
// Define BERT_ERR_INJECT_EN to add inject_err, which inverts rx_data[0] of an accepted word.
module bert_checker_param #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 32,
  parameter int ERR_W       = 16,
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = DATA_W / 2,
  parameter int LOSS_CNT    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [1:0]                   mode,
  input  logic                         rx_valid,
  input  logic [DATA_W-1:0]            rx_data,
`ifdef BERT_ERR_INJECT_EN
  input  logic                         inject_err,
`endif
  output logic                         err_valid,
  output logic [DATA_W-1:0]            err_word,
  output logic [$clog2(DATA_W+1)-1:0]  word_errs,
  output logic [ERR_W-1:0]             total_error,
  output logic [CNT_W-1:0]             count,
  output logic                         locked,
  output logic                         lost_sync
);

  localparam int WE_W = $clog2(DATA_W + 1);
  localparam int GW   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int BW   = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam int ES_W = ((ERR_W > WE_W) ? ERR_W : WE_W) + 1;
  localparam int CS_W = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_CNT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEED   = 2'd1;
  localparam logic [1:0] VERIFY = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  logic [1:0]        state;
  logic [1:0]        mode_q;
  logic [30:0]       lfsr;
  logic [4:0]        seed_cnt;
  logic [GW-1:0]     good_cnt;
  logic [BW-1:0]     bad_cnt;

  logic [DATA_W-1:0] rx_eff;
  logic [30:0]       tap_mask;
  logic [30:0]       ord_mask;
  logic [4:0]        seed_last;
  logic [30:0]       s_v;
  logic              fb_v;
  logic [30:0]       lfsr_next;
  logic [DATA_W-1:0] err_next;
  logic [WE_W-1:0]   errs_next;
  logic              seed_zero;
  logic              bad_word;
  logic              mode_change;
  logic              accept;
  logic              lock_acc;
  logic [ES_W-1:0]   err_sum;
  logic [CS_W-1:0]   cnt_sum;

  always_comb begin
    tap_mask  = 31'h0000_0060;
    ord_mask  = 31'h0000_007F;
    seed_last = 5'((7 + DATA_W - 1) / DATA_W - 1);
    case (mode)
      2'b01: begin
        tap_mask  = 31'h0000_6000;
        ord_mask  = 31'h0000_7FFF;
        seed_last = 5'((15 + DATA_W - 1) / DATA_W - 1);
      end
      2'b10: begin
        tap_mask  = 31'h0042_0000;
        ord_mask  = 31'h007F_FFFF;
        seed_last = 5'((23 + DATA_W - 1) / DATA_W - 1);
      end
      2'b11: begin
        tap_mask  = 31'h4800_0000;
        ord_mask  = 31'h7FFF_FFFF;
        seed_last = 5'((31 + DATA_W - 1) / DATA_W - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_eff = rx_data;
`ifdef BERT_ERR_INJECT_EN
    rx_eff[0] = rx_data[0] ^ inject_err;
`endif
  end

  // Whole word in one cycle, MSB first; SEED loads the received bit instead of feedback.
  always_comb begin
    s_v       = lfsr;
    fb_v      = 1'b0;
    err_next  = '0;
    errs_next = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb_v        = ^(s_v & tap_mask);
      err_next[i] = rx_eff[i] ^ fb_v;
      s_v         = {s_v[29:0], (state == SEED) ? rx_eff[i] : fb_v};
    end
    lfsr_next = s_v;
    for (int i = 0; i < DATA_W; i++) begin
      errs_next = errs_next + WE_W'(err_next[i]);
    end
  end

  assign seed_zero   = ((lfsr_next & ord_mask) == 31'd0);
  assign bad_word    = (errs_next >= WE_W'(LOSS_THRESH));
  assign mode_change = (mode != mode_q);
  assign accept      = enable && (state != IDLE) && !mode_change && rx_valid;
  assign lock_acc    = accept && (state == LOCKED);
  assign err_sum     = ES_W'(total_error) + ES_W'(errs_next);
  assign cnt_sum     = CS_W'(count) + CS_W'(DATA_W);
  assign locked      = (state == LOCKED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      lfsr      <= '0;
      seed_cnt  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      err_valid <= 1'b0;
      err_word  <= '0;
      word_errs <= '0;
      lost_sync <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      lost_sync <= 1'b0;
      mode_q    <= mode;
      if (!enable) begin
        state <= IDLE;
      end else if (state == IDLE || mode_change) begin
        state    <= SEED;
        seed_cnt <= '0;
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else if (rx_valid) begin
        lfsr <= lfsr_next;
        if (state == SEED) begin
          if (seed_cnt == seed_last) begin
            seed_cnt <= '0;
            if (!seed_zero) begin
              state    <= VERIFY;
              good_cnt <= '0;
            end
          end else begin
            seed_cnt <= seed_cnt + 5'd1;
          end
        end else begin
          err_valid <= 1'b1;
          err_word  <= err_next;
          word_errs <= errs_next;
          if (state == VERIFY) begin
            if (|err_next) begin
              state    <= SEED;
              seed_cnt <= '0;
              good_cnt <= '0;
            end else if (good_cnt == LOCK_LAST) begin
              state   <= LOCKED;
              bad_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end else if (!bad_word) begin
            bad_cnt <= '0;
          end else if (bad_cnt == LOSS_LAST) begin
            state     <= SEED;
            lost_sync <= 1'b1;
            seed_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
          end else begin
            bad_cnt <= bad_cnt + BW'(1);
          end
        end
      end
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_error <= '0;
      count       <= '0;
    end else if (clear) begin
      total_error <= '0;
      count       <= '0;
    end else if (lock_acc) begin
      total_error <= (|err_sum[ES_W-1:ERR_W]) ? '1 : err_sum[ERR_W-1:0];
      count       <= (|cnt_sum[CS_W-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_bert_checker_param.sv
// tb/tb_bert_checker_param.sv - scoreboard bench for bert_checker_param (DATA_W=8, ERR_W=4)
module tb_bert_checker_param;

  logic        clock = 1'b0;
  logic        reset, enable, clear, rx_valid;
  logic [1:0]  mode;
  logic [7:0]  rx_data;
  logic        err_valid, locked, lost_sync;
  logic [7:0]  err_word;
  logic [3:0]  word_errs;
  logic [3:0]  total_error;
  logic [31:0] count;

  bert_checker_param #(.DATA_W(8), .CNT_W(32), .ERR_W(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .mode(mode),
    .rx_valid(rx_valid), .rx_data(rx_data),
`ifdef BERT_ERR_INJECT_EN
    .inject_err(1'b0),
`endif
    .err_valid(err_valid), .err_word(err_word), .word_errs(word_errs),
    .total_error(total_error), .count(count), .locked(locked), .lost_sync(lost_sync)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] ew; int n; bit lost; } exp_t;
  exp_t expq[$];
  exp_t mon_e;
  int checks = 0, fails = 0, ev_seen = 0, lost_seen = 0;

  // reference model: 0 idle, 1 seed, 2 verify, 3 locked; bit histories, newest last
  int mst = 0, msc = 0, mgood = 0, mbad = 0, mtot = 0;
  longint mcnt = 0;
  logic [1:0] mmq = 2'b00;
  logic [1:0] cur_mode = 2'b00;
  bit mh[$];
  bit src[$];

  function automatic int ord(input logic [1:0] m);
    case (m) 2'b00: return 7; 2'b01: return 15; 2'b10: return 23; default: return 31; endcase
  endfunction

  function automatic int tap2(input logic [1:0] m);
    case (m) 2'b00: return 6; 2'b01: return 14; 2'b10: return 18; default: return 28; endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (lost_sync && !err_valid) chk("lost_sync_without_word", 1, 0);
      if (err_valid) begin
        ev_seen++;
        if (expq.size() == 0) begin
          chk("unexpected_err_valid", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          chk("err_word", err_word, mon_e.ew);
          chk("word_errs", word_errs, mon_e.n);
          chk("lost_sync", lost_sync, mon_e.lost);
        end
      end
      if (lost_sync) lost_seen++;
    end
  end

  task automatic step(input bit en, input bit v, input logic [7:0] d, input bit clr);
    bit lost = 0;
    bit allz, e;
    int p = ord(mode), q = tap2(mode), n;
    logic [7:0] ew;
    if (!en) mst = 0;
    else if (mst == 0 || mode != mmq) begin
      mst = 1; msc = 0; mgood = 0; mbad = 0;
    end else if (v) begin
      if (mst == 1) begin
        for (int i = 7; i >= 0; i--) mh.push_back(d[i]);
        while (mh.size() > 31) void'(mh.pop_front());
        msc++;
        if (msc == (p + 7) / 8) begin
          msc = 0;
          allz = 1;
          for (int k = 1; k <= p; k++) if (mh[mh.size() - k]) allz = 0;
          if (!allz) begin mst = 2; mgood = 0; end
        end
      end else begin
        ew = 8'h00;
        for (int i = 7; i >= 0; i--) begin
          e = mh[mh.size() - p] ^ mh[mh.size() - q];
          mh.push_back(e);
          ew[i] = d[i] ^ e;
        end
        while (mh.size() > 31) void'(mh.pop_front());
        n = $countones(ew);
        if (mst == 2) begin
          if (n != 0) begin mst = 1; msc = 0; mgood = 0; end
          else begin
            mgood++;
            if (mgood == 4) begin mst = 3; mbad = 0; end
          end
        end else begin
          if (!clr) begin
            mtot = (mtot + n > 15) ? 15 : mtot + n;
            mcnt = (mcnt + 8 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mcnt + 8;
          end
          if (n >= 4) mbad++; else mbad = 0;
          if (mbad == 4) begin lost = 1; mst = 1; msc = 0; mgood = 0; mbad = 0; end
        end
        expq.push_back('{ew, n, lost});
      end
    end
    if (clr) begin mtot = 0; mcnt = 0; end
    mmq = mode;
  endtask

  task automatic cyc(input bit en, input bit v, input logic [7:0] d, input bit clr);
    @(negedge clock);
    enable = en; rx_valid = v; rx_data = d; clear = clr; mode = cur_mode;
    step(en, v, d, clr);
    @(posedge clock);
    #1;
    chk("locked", locked, mst == 3);
    chk("total_error", total_error, mtot);
    chk("count", count, mcnt);
  endtask

  task automatic gen_seed(input logic [30:0] v);
    src.delete();
    for (int k = ord(cur_mode) - 1; k >= 0; k--) src.push_back(v[k]);
  endtask

  task automatic gen_word(output logic [7:0] w);
    int p = ord(cur_mode), q = tap2(cur_mode);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      b = src[src.size() - p] ^ src[src.size() - q];
      src.push_back(b);
      if (src.size() > 31) void'(src.pop_front());
      w[i] = b;
    end
  endtask

  logic [7:0] w, flip;
  int ls0, ev0;
  bit v, clr;
  logic [1:0] mseq [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; mode = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_word", err_word, 0);
    chk("rst_word_errs", word_errs, 0);
    chk("rst_total", total_error, 0);
    chk("rst_count", count, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lost", lost_sync, 0);
    @(negedge clock) reset = 1'b1;
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("idle_err_valid", err_valid, 0);

    // PRBS7 clean lock: one seed word, four verify words
    cur_mode = 2'b00;
    gen_seed(31'h7F);
    cyc(1, 0, 8'h00, 0);
    gen_word(w); cyc(1, 1, w, 0);
    for (int k = 0; k < 4; k++) begin
      gen_word(w); cyc(1, 1, w, 0);
      chk("lock_after_clean_words", locked, (k == 3) ? 1 : 0);
    end
    repeat (10) begin gen_word(w); cyc(1, 1, w, 0); end
    chk("count_10_words", count, 80);
    chk("total_clean", total_error, 0);

    // single-bit errors on bit 3
    for (int k = 0; k < 3; k++) begin
      gen_word(w); cyc(1, 1, w ^ 8'h08, 0);
      gen_word(w); cyc(1, 1, w, 0);
    end
    chk("total_three_errors", total_error, 3);
    chk("locked_after_errors", locked, 1);

    // loss of sync, then re-lock
    ls0 = lost_seen;
    for (int k = 0; k < 4; k++) begin
      gen_word(w);
      cyc(1, 1, ($countones(w) >= 4) ? 8'h00 : 8'hFF, 0);
    end
    cyc(1, 0, 8'h00, 0);
    chk("lost_sync_pulses", lost_seen - ls0, 1);
    chk("unlocked_after_loss", locked, 0);
    repeat (5) begin gen_word(w); cyc(1, 1, w, 0); end
    chk("relock", locked, 1);

    // all-zero input never leaves SEED
    cyc(0, 0, 8'h00, 0);
    ev0 = ev_seen;
    cyc(1, 0, 8'h00, 0);
    repeat (20) cyc(1, 1, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    chk("zero_no_err_valid", ev_seen - ev0, 0);
    chk("zero_not_locked", locked, 0);

    // saturation and clear collision
    gen_seed(31'h7F);
    repeat (5) begin gen_word(w); cyc(1, 1, w, 0); end
    chk("relock_for_sat", locked, 1);
    gen_word(w); cyc(1, 1, w, 1);
    repeat (20) begin gen_word(w); cyc(1, 1, w ^ 8'h01, 0); end
    chk("total_saturated", total_error, 15);
    repeat (3) begin gen_word(w); cyc(1, 1, w ^ 8'h01, 0); end
    chk("total_holds", total_error, 15);
    gen_word(w); cyc(1, 1, w ^ 8'h01, 1);
    chk("clear_beats_increment", total_error, 0);

    // randomized streams across all polynomials, switching mode while enabled
    for (int mi = 0; mi < 4; mi++) begin
      cur_mode = mseq[mi];
      gen_seed(31'($urandom) | 31'd1);
      for (int c = 0; c < 80; c++) begin
        v = ($urandom_range(3) != 0);
        clr = ($urandom_range(19) == 0);
        flip = ($urandom_range(9) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
        w = 8'h00;
        if (v) gen_word(w);
        cyc(1, v, w ^ flip, clr);
      end
      repeat (20) begin gen_word(w); cyc(1, 1, w, 0); end
      chk("random_lock", locked, 1);
    end
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    chk("scoreboard_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
